sirv_uart_tx_fifo: RTL and testbench

//  Parametrised UART transmit channel: DEPTH-entry TX FIFO, baud prescaler and frame serializer.

---
 rtl/sirv_uart_tx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_sirv_uart_tx_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_uart_tx_fifo.sv
// UART transmit channel: DEPTH-entry byte FIFO, baud prescaler and a frame serializer
// with runtime 5..8 data bits, optional even/odd parity, 1 or 2 stop bits and a
// FIFO watermark interrupt.
module sirv_uart_tx_fifo #(
   parameter  int unsigned DEPTH = 8,
   parameter  int unsigned DIV_W = 16,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             nstop,
   input  logic [1:0]       dlen,
   input  logic             par_en,
   input  logic             par_odd,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_bits,
   input  logic [CNT_W-1:0] txwm,
   output logic [CNT_W-1:0] count,
   output logic             irq_txwm,
   output logic             busy,
   output logic             txd
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [2:0]       state_q, state_d;
   logic             txd_q, txd_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [1:0]       dlen_q, dlen_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic             nstop_q, nstop_d;

   logic             enq, deq, bit_end, last_data;
   logic [7:0]       head, dmask;

   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign count     = count_q;
   assign irq_txwm  = (count_q < txwm);
   assign busy      = (state_q != ST_IDLE);
   assign txd       = txd_q;

   assign enq       = in_valid && in_ready;
   assign deq       = (state_q == ST_IDLE) && en && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];
   // Keep only the 5+dlen bits that will be transmitted so parity ignores the rest.
   assign dmask     = 8'hFF >> (2'd3 - dlen);
   assign bit_end   = (presc_q == '0);
   assign last_data = (bit_cnt_q == ({1'b0, dlen_q} + 3'd4));

   // FIFO pointers and occupancy; enq and deq together leave count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq && !deq) begin
         count_d = count_q + CNT_W'(1);
      end else if (!enq && deq) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Frame serializer: each bit is held for div+1 clocks via the prescaler.
   always_comb begin
      state_d   = state_q;
      txd_d     = txd_q;
      presc_d   = presc_q;
      div_d     = div_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      dlen_d    = dlen_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      nstop_d   = nstop_q;
      if (state_q != ST_IDLE && !bit_end) presc_d = presc_q - DIV_W'(1);
      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (deq) begin
               state_d   = ST_START;
               txd_d     = 1'b0;
               presc_d   = div;
               div_d     = div;
               shift_d   = head;
               bit_cnt_d = 3'd0;
               dlen_d    = dlen;
               par_en_d  = par_en;
               par_bit_d = (^(head & dmask)) ^ par_odd;
               nstop_d   = nstop;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
               presc_d = div_q;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               presc_d = div_q;
               if (last_data) begin
                  bit_cnt_d = 3'd0;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     txd_d   = par_bit_q;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  txd_d     = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
               presc_d = div_q;
            end
         end
         ST_STOP: begin
            txd_d = 1'b1;
            if (bit_end) begin
               // bit_cnt counts stop bits already sent when two are requested.
               if (nstop_q && bit_cnt_q == 3'd0) begin
                  bit_cnt_d = 3'd1;
                  presc_d   = div_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clock) begin
      if (enq) mem_q[wr_ptr_q] <= in_bits;
   end

   // Control state with synchronous reset; reset aborts any frame in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= ST_IDLE;
         txd_q     <= 1'b1;
         presc_q   <= '0;
         div_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         dlen_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         nstop_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         txd_q     <= txd_d;
         presc_q   <= presc_d;
         div_q     <= div_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         dlen_q    <= dlen_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         nstop_q   <= nstop_d;
      end
   end

endmodule

// File: tb/tb_sirv_uart_tx_fifo.sv
// Bench for sirv_uart_tx_fifo: a queue/waveform model checked every cycle plus
// hand-computed frame expectations for the directed cases.
module tb_sirv_uart_tx_fifo;

   localparam int DEPTH = 8;
   localparam int DIV_W = 16;
   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             en = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic             nstop = 1'b0;
   logic [1:0]       dlen = 2'd3;
   logic             par_en = 1'b0;
   logic             par_odd = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_bits = '0;
   logic [CNT_W-1:0] txwm = 4'd1;
   logic             in_ready, irq_txwm, busy, txd;
   logic [CNT_W-1:0] count;

   sirv_uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .div     (div),
      .nstop   (nstop),
      .dlen    (dlen),
      .par_en  (par_en),
      .par_odd (par_odd),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_bits (in_bits),
      .txwm    (txwm),
      .count   (count),
      .irq_txwm(irq_txwm),
      .busy    (busy),
      .txd     (txd)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a byte queue plus the list of txd levels (one per clock) still to be sent.
   byte unsigned mq[$];
   bit           wave[$];
   bit           m_txd = 1'b1;
   bit           m_busy = 1'b0;

   function automatic void push_level(input bit v);
      for (int r = 0; r < int'(div) + 1; r++) wave.push_back(v);
   endfunction

   function automatic void build_frame(input byte unsigned b);
      bit p;
      p = par_odd;
      push_level(1'b0);
      for (int i = 0; i < 5 + int'(dlen); i++) begin
         push_level(b[i]);
         p ^= b[i];
      end
      if (par_en) push_level(p);
      push_level(1'b1);
      if (nstop) push_level(1'b1);
   endfunction

   always @(posedge clock) begin : model_p
      bit can_push;
      if (reset) begin
         mq.delete();
         wave.delete();
         m_txd  = 1'b1;
         m_busy = 1'b0;
      end else begin
         can_push = in_valid && (mq.size() < DEPTH);
         if (wave.size() > 0) begin
            m_txd  = wave.pop_front();
            m_busy = 1'b1;
         end else if (m_busy) begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
         end else if (en && mq.size() > 0) begin
            build_frame(mq.pop_front());
            m_txd  = wave.pop_front();
            m_busy = 1'b1;
         end else begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
         end
         if (can_push) mq.push_back(in_bits);
      end
      #1;
      check("txd", 32'(txd), 32'(m_txd));
      check("busy", 32'(busy), 32'(m_busy));
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      check("irq_txwm", 32'(irq_txwm), 32'(mq.size() < int'(txwm)));
   end

   logic txd_log [0:199];
   logic busy_log[0:199];

   task automatic record(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
         txd_log[k]  = txd;
         busy_log[k] = busy;
      end
   endtask

   function automatic int first_low(input int n);
      for (int k = 0; k < n; k++) if (txd_log[k] === 1'b0) return k;
      return -1;
   endfunction

   task automatic push(input logic [7:0] b);
      @(negedge clock);
      in_valid = 1'b1;
      in_bits  = b;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int k;
      k = 0;
      while (!(count == '0 && busy == 1'b0) && k < maxc) begin
         @(negedge clock);
         k++;
      end
      check(name, 32'(k < maxc), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0, busy_sum;
      logic [9:0] got;

      // Reset state
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_irq_txwm1", 32'(irq_txwm), 32'd1);
      txwm = 4'd0;
      #1;
      check("rst_irq_txwm0", 32'(irq_txwm), 32'd0);
      txwm = 4'd1;

      // 8N1, div=3, byte 0x55
      @(negedge clock);
      div = 16'd3; dlen = 2'd3; par_en = 1'b0; nstop = 1'b0; en = 1'b1;
      push(8'h55);
      record(50);
      t0 = first_low(50);
      check("t2_start_found", 32'(t0 >= 0), 32'd1);
      if (t0 < 0) t0 = 0;
      for (int i = 0; i < 10; i++) got[i] = txd_log[t0 + 4 * i + 2];
      check("t2_frame", 32'(got), 32'(10'b1010101010));
      busy_sum = 0;
      for (int k = 0; k < 50; k++) if (busy_log[k] === 1'b1) busy_sum++;
      check("t2_busy_clocks", 32'(busy_sum), 32'd40);
      check("t2_start_len", 32'({txd_log[t0 + 3], txd_log[t0 + 4]}), 32'(2'b01));
      check("t2_count", 32'(count), 32'd0);

      // 7 data bits + parity, byte 0x87
      @(negedge clock);
      div = 16'd0; dlen = 2'd2; par_en = 1'b1; par_odd = 1'b0;
      push(8'h87);
      record(20);
      t0 = first_low(20);
      if (t0 < 0) t0 = 0;
      for (int i = 0; i < 10; i++) got[i] = txd_log[t0 + i];
      check("t3_even_frame", 32'(got), 32'(10'b1100001110));
      check("t3_gap", 32'({txd_log[t0 + 10], busy_log[t0 + 10]}), 32'(2'b10));
      @(negedge clock);
      par_odd = 1'b1;
      push(8'h87);
      record(20);
      t0 = first_low(20);
      if (t0 < 0) t0 = 0;
      for (int i = 0; i < 10; i++) got[i] = txd_log[t0 + i];
      check("t3_odd_frame", 32'(got), 32'(10'b1000001110));

      // Fill past full with en=0, then drain in order
      @(negedge clock);
      en = 1'b0; txwm = 4'd4; div = 16'd0; dlen = 2'd3; par_en = 1'b0; par_odd = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         in_bits = 8'h10 + 8'(k);
         @(negedge clock);
      end
      in_valid = 1'b0;
      check("t4_count_full", 32'(count), 32'd8);
      check("t4_in_ready_full", 32'(in_ready), 32'd0);
      check("t4_irq_full", 32'(irq_txwm), 32'd0);
      en = 1'b1;
      wait_idle(200, "t4_drain_timeout");
      check("t4_irq_empty", 32'(irq_txwm), 32'd1);

      // Full FIFO with in_valid in the pop cycle: push refused
      @(negedge clock);
      en = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_bits = 8'hA0 + 8'(k);
         @(negedge clock);
      end
      check("t5_count_full", 32'(count), 32'd8);
      en = 1'b1;
      in_bits = 8'hEE;
      @(negedge clock);
      in_valid = 1'b0;
      check("t5_count_after_pop", 32'(count), 32'd7);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      wait_idle(200, "t5_drain_timeout");

      // Two stop bits at div=0
      @(negedge clock);
      nstop = 1'b1; div = 16'd0; dlen = 2'd3;
      push(8'hFF);
      record(20);
      t0 = first_low(20);
      if (t0 < 0) t0 = 0;
      check("t6_stop_bits", 32'({txd_log[t0 + 9], txd_log[t0 + 10]}), 32'(2'b11));
      check("t6_busy_end", 32'({busy_log[t0 + 10], busy_log[t0 + 11]}), 32'(2'b10));

      // Reset in the middle of the data bits
      @(negedge clock);
      nstop = 1'b0; div = 16'd3;
      push(8'h00);
      push(8'h00);
      repeat (6) @(negedge clock);
      check("t6_mid_data_txd", 32'(txd), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("t6_rst_txd", 32'(txd), 32'd1);
      check("t6_rst_count", 32'(count), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      repeat (10) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
